// File: rtl/lcd_cmd_port.sv
// lcd_cmd_port: Avalon-MM slave that queues HD44780-style LCD commands/data
// in a FIFO and replays them onto the LCD bus with programmable setup,
// enable-pulse and inter-command gap timing.
`timescale 1ns/1ps
module lcd_cmd_port #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int SETUP_CYC  = 2,
    parameter int E_CYC      = 12,
    parameter int GAP_CYC    = 2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] lcd_data,
    output logic              lcd_rs,
    output logic              lcd_e,
    output logic              lcd_rw
);
    localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [8:0] DEPTH   = 9'(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // Each entry is {rs, data}; storage is not reset, occupancy is tracked by count_q.
    logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [8:0]        count_q, count_d;
    logic              ovf_q, ovf_d, en_q, en_d;
    logic [DATA_W-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
    logic [1:0]        state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rs_q, rs_d, e_q, e_d;

    logic              wr_en, push_req, flush, push_ok, drop, pop, empty, full;
    logic [DATA_W:0]   head;
    logic              unused_ok;

    assign lcd_data  = data_q;
    assign lcd_rs    = rs_q;
    assign lcd_e     = e_q;
    assign lcd_rw    = 1'b0;
    assign unused_ok = ^writedata;

    // Bus decode and FIFO handshake; flush beats a same-cycle push, a pop frees a slot for a push when full.
    always_comb begin
        wr_en    = chipselect & ~write_n;
        push_req = wr_en & ~address[1];
        flush    = wr_en & (address == 2'd3) & writedata[1];
        empty    = (count_q == 9'd0);
        full     = (count_q == DEPTH);
        head     = fifo_mem[rd_ptr_q];
        pop      = (state_q == S_IDLE) & en_q & ~empty;
        push_ok  = push_req & ~flush & (~full | pop);
        drop     = push_req & ~flush & full & ~pop;
    end

    // FIFO pointers and occupancy; pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + 9'(push_ok) - 9'(pop);
        end
    end

    // Software-visible registers: overflow flag, enable bit and per-address shadows of accepted pushes.
    always_comb begin
        ovf_d = ovf_q;
        en_d  = en_q;
        sh0_d = sh0_q;
        sh1_d = sh1_q;
        if (drop) ovf_d = 1'b1;
        if (wr_en && (address == 2'd2) && writedata[3]) ovf_d = 1'b0;
        if (wr_en && (address == 2'd3)) en_d = writedata[0];
        if (push_ok && !address[0]) sh0_d = writedata[DATA_W-1:0];
        if (push_ok &&  address[0]) sh1_d = writedata[DATA_W-1:0];
    end

    // Transfer sequencer; lcd_e is registered so it changes only on clock edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        e_d     = e_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_SETUP;
                    cnt_d   = 32'(SETUP_CYC - 1);
                    data_d  = head[DATA_W-1:0];
                    rs_d    = head[DATA_W];
                    e_d     = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_q == 32'd0) begin
                    state_d = S_PULSE;
                    cnt_d   = 32'(E_CYC - 1);
                    e_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_PULSE: begin
                if (cnt_q == 32'd0) begin
                    state_d = S_GAP;
                    cnt_d   = 32'(GAP_CYC - 1);
                    e_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                if (cnt_q == 32'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
        endcase
    end

    // Zero-wait-state read mux.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[DATA_W-1:0] = sh0_q;
            2'd1: readdata[DATA_W-1:0] = sh1_q;
            2'd2: begin
                readdata[0]     = empty;
                readdata[1]     = full;
                readdata[2]     = (state_q != S_IDLE);
                readdata[3]     = ovf_q;
                readdata[24:16] = count_q;
            end
            default: readdata[0] = en_q;
        endcase
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= {address[0], writedata[DATA_W-1:0]};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            en_q     <= 1'b0;
            sh0_q    <= '0;
            sh1_q    <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            rs_q     <= 1'b0;
            e_q      <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            en_q     <= en_d;
            sh0_q    <= sh0_d;
            sh1_q    <= sh1_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            e_q      <= e_d;
        end
    end
endmodule

// File: tb/tb_lcd_cmd_port.sv
// Testbench for lcd_cmd_port: a default-parameter instance (A) and a small
// FIFO_DEPTH=4 / DATA_W=4 instance (B) with short timing. Expected LCD
// transfers are queued when pushed and popped when an E pulse appears.
`timescale 1ns/1ps
module tb_lcd_cmd_port;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [1:0]  a_address;
    logic        a_cs, a_wn;
    logic [31:0] a_wdata, a_rdata;
    logic [7:0]  a_lcd_data;
    logic        a_rs, a_e, a_rw;

    logic [1:0]  b_address;
    logic        b_cs, b_wn;
    logic [31:0] b_wdata, b_rdata;
    logic [3:0]  b_lcd_data;
    logic        b_rs, b_e, b_rw;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_a[$];
    logic [4:0] exp_b[$];
    logic [8:0] ea;
    logic [4:0] eb;
    int pulses_a = 0;
    int pulses_b = 0;
    logic a_e_prev = 1'b0;
    logic b_e_prev = 1'b0;

    lcd_cmd_port dut_a (
        .clk(clk), .reset(reset), .address(a_address), .chipselect(a_cs),
        .write_n(a_wn), .writedata(a_wdata), .readdata(a_rdata),
        .lcd_data(a_lcd_data), .lcd_rs(a_rs), .lcd_e(a_e), .lcd_rw(a_rw)
    );

    lcd_cmd_port #(.DATA_W(4), .FIFO_DEPTH(4), .SETUP_CYC(1), .E_CYC(2), .GAP_CYC(3)) dut_b (
        .clk(clk), .reset(reset), .address(b_address), .chipselect(b_cs),
        .write_n(b_wn), .writedata(b_wdata), .readdata(b_rdata),
        .lcd_data(b_lcd_data), .lcd_rs(b_rs), .lcd_e(b_e), .lcd_rw(b_rw)
    );

    // Scoreboard: every rising E must match the oldest expected entry.
    always @(negedge clk) begin
        if (a_e === 1'b1 && a_e_prev === 1'b0) begin
            pulses_a++;
            n_checks++;
            if (exp_a.size() == 0) begin
                n_fail++;
                $display("FAIL a_pulse_unexpected: got rs=%0b data=0x%02h, expected no E pulse", a_rs, a_lcd_data);
            end else begin
                ea = exp_a.pop_front();
                if ({a_rs, a_lcd_data} !== ea) begin
                    n_fail++;
                    $display("FAIL a_pulse_entry: got rs=%0b data=0x%02h, expected rs=%0b data=0x%02h",
                             a_rs, a_lcd_data, ea[8], ea[7:0]);
                end
            end
        end
        a_e_prev = a_e;
        if (b_e === 1'b1 && b_e_prev === 1'b0) begin
            pulses_b++;
            n_checks++;
            if (exp_b.size() == 0) begin
                n_fail++;
                $display("FAIL b_pulse_unexpected: got rs=%0b data=0x%0h, expected no E pulse", b_rs, b_lcd_data);
            end else begin
                eb = exp_b.pop_front();
                if ({b_rs, b_lcd_data} !== eb) begin
                    n_fail++;
                    $display("FAIL b_pulse_entry: got rs=%0b data=0x%0h, expected rs=%0b data=0x%0h",
                             b_rs, b_lcd_data, eb[4], eb[3:0]);
                end
            end
        end
        b_e_prev = b_e;
    end

    task automatic bus_idle();
        a_cs = 1'b0; a_wn = 1'b1;
        b_cs = 1'b0; b_wn = 1'b1;
    endtask

    task automatic wr(input bit b, input logic [1:0] ad, input logic [31:0] d);
        if (!b) begin a_address = ad; a_wdata = d; a_cs = 1'b1; a_wn = 1'b0; end
        else    begin b_address = ad; b_wdata = d; b_cs = 1'b1; b_wn = 1'b0; end
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic rd(input bit b, input logic [1:0] ad, output logic [31:0] d);
        if (!b) begin a_address = ad; a_cs = 1'b1; a_wn = 1'b1; end
        else    begin b_address = ad; b_cs = 1'b1; b_wn = 1'b1; end
        #1;
        d = b ? b_rdata : a_rdata;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic push_a(input logic [1:0] ad, input logic [7:0] d, input bit expect_out);
        if (expect_out) exp_a.push_back({ad[0], d});
        wr(1'b0, ad, {24'h0, d});
    endtask

    task automatic push_b(input logic [1:0] ad, input logic [3:0] d);
        exp_b.push_back({ad[0], d});
        wr(1'b1, ad, {28'h0, d});
    endtask

    // Hold a status read until busy drops; cyc reports clocks waited.
    task automatic wait_not_busy(input bit b, input int bound, output int cyc);
        if (!b) begin a_address = 2'd2; a_cs = 1'b1; a_wn = 1'b1; end
        else    begin b_address = 2'd2; b_cs = 1'b1; b_wn = 1'b1; end
        #1;
        cyc = 0;
        while ((b ? b_rdata[2] : a_rdata[2]) !== 1'b0 && cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus_idle();
    endtask

    // Hold a status read until the port is empty and idle.
    task automatic wait_drained(input bit b, input int bound, output int cyc);
        if (!b) begin a_address = 2'd2; a_cs = 1'b1; a_wn = 1'b1; end
        else    begin b_address = 2'd2; b_cs = 1'b1; b_wn = 1'b1; end
        #1;
        cyc = 0;
        while ((b ? b_rdata : a_rdata) !== 32'h1 && cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus_idle();
    endtask

    task automatic wait_e_a(input int bound, output int cyc);
        cyc = 0;
        while (a_e !== 1'b1 && cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (a_e !== 1'b0) begin n_fail++; $display("FAIL reset_lcd_e: got %b, expected 0", a_e); end
        n_checks++; if (a_lcd_data !== 8'h00) begin n_fail++; $display("FAIL reset_lcd_data: got 0x%02h, expected 0x00", a_lcd_data); end
        n_checks++; if (a_rs !== 1'b0) begin n_fail++; $display("FAIL reset_lcd_rs: got %b, expected 0", a_rs); end
        n_checks++; if (a_rw !== 1'b0) begin n_fail++; $display("FAIL reset_lcd_rw: got %b, expected 0", a_rw); end
        rd(1'b0, 2'd2, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL reset_status: got 0x%08h, expected 0x00000001", v); end
        reset = 1'b0;
        rd(1'b0, 2'd3, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_control: got 0x%08h, expected 0x00000000", v); end
        rd(1'b0, 2'd0, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_shadow0: got 0x%08h, expected 0x00000000", v); end
        rd(1'b1, 2'd2, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL reset_status_b: got 0x%08h, expected 0x00000001", v); end
    endtask

    task automatic test_single_cmd();
        logic [31:0] v;
        int n, h, g;
        wr(1'b0, 2'd3, 32'h1);
        push_a(2'd0, 8'h38, 1'b1);
        @(posedge clk); #1;
        n_checks++; if ({a_rs, a_lcd_data} !== 9'h038) begin n_fail++; $display("FAIL single_setup_bus: got rs=%0b data=0x%02h, expected rs=0 data=0x38", a_rs, a_lcd_data); end
        n_checks++; if (a_e !== 1'b0) begin n_fail++; $display("FAIL single_setup_e: got %b, expected 0", a_e); end
        wait_e_a(50, n);
        n_checks++; if (n != 2) begin n_fail++; $display("FAIL single_e_rise_delay: got %0d, expected 2", n); end
        h = 0;
        while (a_e === 1'b1 && h < 100) begin @(posedge clk); #1; h++; end
        n_checks++; if (h != 12) begin n_fail++; $display("FAIL single_e_width: got %0d, expected 12", h); end
        wait_not_busy(1'b0, 3000, g);
        n_checks++; if (g != 2000) begin n_fail++; $display("FAIL single_gap: got %0d, expected 2000", g); end
        rd(1'b0, 2'd0, v);
        n_checks++; if (v !== 32'h38) begin n_fail++; $display("FAIL single_shadow0: got 0x%08h, expected 0x00000038", v); end
        n_checks++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL single_sb_left: got %0d, expected 0", exp_a.size()); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        wr(1'b0, 2'd3, 32'h0);
        for (int i = 0; i < 17; i++) push_a(2'(i % 2), 8'(8'h40 + i), 1'b0);
        rd(1'b0, 2'd2, v);
        n_checks++; if (v !== 32'h0010_000A) begin n_fail++; $display("FAIL ovf_status_full: got 0x%08h, expected 0x0010000a", v); end
        wr(1'b0, 2'd2, 32'h8);
        rd(1'b0, 2'd2, v);
        n_checks++; if (v !== 32'h0010_0002) begin n_fail++; $display("FAIL ovf_cleared: got 0x%08h, expected 0x00100002", v); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] v;
        int g;
        exp_a.push_back({1'b0, 8'h40});
        wr(1'b0, 2'd3, 32'h1);
        push_a(2'd0, 8'hAA, 1'b0);
        rd(1'b0, 2'd2, v);
        n_checks++; if (v !== 32'h0010_0006) begin n_fail++; $display("FAIL fullpp_status: got 0x%08h, expected 0x00100006", v); end
        rd(1'b0, 2'd0, v);
        n_checks++; if (v !== 32'hAA) begin n_fail++; $display("FAIL fullpp_shadow0: got 0x%08h, expected 0x000000aa", v); end
        wr(1'b0, 2'd3, 32'h3);
        rd(1'b0, 2'd2, v);
        n_checks++; if (v !== 32'h5) begin n_fail++; $display("FAIL fullpp_flushed: got 0x%08h, expected 0x00000005", v); end
        wait_not_busy(1'b0, 3000, g);
        n_checks++; if (g >= 3000) begin n_fail++; $display("FAIL fullpp_busy_timeout: got %0d cycles, expected < 3000", g); end
        rd(1'b0, 2'd2, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL fullpp_final_status: got 0x%08h, expected 0x00000001", v); end
        n_checks++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL fullpp_sb_left: got %0d, expected 0", exp_a.size()); end
    endtask

    task automatic test_flush_in_pulse();
        logic [31:0] v;
        int p0, n, h, g;
        p0 = pulses_a;
        push_a(2'd1, 8'h51, 1'b1);
        push_a(2'd0, 8'h52, 1'b0);
        push_a(2'd1, 8'h53, 1'b0);
        wait_e_a(50, n);
        n_checks++; if (n >= 50) begin n_fail++; $display("FAIL flush_e_timeout: got %0d cycles, expected < 50", n); end
        h = 1;
        wr(1'b0, 2'd3, 32'h3);
        if (a_e === 1'b1) h++;
        while (a_e === 1'b1 && h < 100) begin @(posedge clk); #1; if (a_e === 1'b1) h++; end
        n_checks++; if (h != 12) begin n_fail++; $display("FAIL flush_e_width: got %0d, expected 12", h); end
        rd(1'b0, 2'd2, v);
        n_checks++; if (v !== 32'h5) begin n_fail++; $display("FAIL flush_status_gap: got 0x%08h, expected 0x00000005", v); end
        wait_not_busy(1'b0, 2100, g);
        n_checks++; if (g >= 2100) begin n_fail++; $display("FAIL flush_busy_timeout: got %0d cycles, expected < 2100", g); end
        repeat (50) @(posedge clk);
        #1;
        n_checks++; if (pulses_a - p0 != 1) begin n_fail++; $display("FAIL flush_pulse_count: got %0d, expected 1", pulses_a - p0); end
        rd(1'b0, 2'd2, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL flush_final_status: got 0x%08h, expected 0x00000001", v); end
        n_checks++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL flush_sb_left: got %0d, expected 0", exp_a.size()); end
    endtask

    task automatic test_reset_in_pulse();
        logic [31:0] v;
        int n;
        push_a(2'd0, 8'h77, 1'b1);
        wait_e_a(50, n);
        n_checks++; if (a_e !== 1'b1) begin n_fail++; $display("FAIL rstp_e_before: got %b, expected 1", a_e); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (a_e !== 1'b0) begin n_fail++; $display("FAIL rstp_e_drop: got %b, expected 0", a_e); end
        n_checks++; if ({a_rs, a_lcd_data} !== 9'h000) begin n_fail++; $display("FAIL rstp_bus: got rs=%0b data=0x%02h, expected rs=0 data=0x00", a_rs, a_lcd_data); end
        rd(1'b0, 2'd2, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL rstp_status: got 0x%08h, expected 0x00000001", v); end
        reset = 1'b0;
        rd(1'b0, 2'd3, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL rstp_control: got 0x%08h, expected 0x00000000", v); end
        rd(1'b0, 2'd0, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL rstp_shadow0: got 0x%08h, expected 0x00000000", v); end
        rd(1'b0, 2'd1, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL rstp_shadow1: got 0x%08h, expected 0x00000000", v); end
        repeat (30) @(posedge clk);
        #1;
        n_checks++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL rstp_sb_left: got %0d, expected 0", exp_a.size()); end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        int g;
        for (int i = 1; i <= 4; i++) push_b(2'(i % 2), 4'(i));
        rd(1'b1, 2'd2, v);
        n_checks++; if (v !== 32'h0004_0002) begin n_fail++; $display("FAIL wrap_full: got 0x%08h, expected 0x00040002", v); end
        rd(1'b1, 2'd1, v);
        n_checks++; if (v !== 32'h3) begin n_fail++; $display("FAIL wrap_shadow1: got 0x%08h, expected 0x00000003", v); end
        wr(1'b1, 2'd3, 32'h1);
        wait_drained(1'b1, 200, g);
        n_checks++; if (g >= 200) begin n_fail++; $display("FAIL wrap_drain1_timeout: got %0d cycles, expected < 200", g); end
        for (int i = 5; i <= 6; i++) push_b(2'(i % 2), 4'(i));
        wait_drained(1'b1, 200, g);
        n_checks++; if (g >= 200) begin n_fail++; $display("FAIL wrap_drain2_timeout: got %0d cycles, expected < 200", g); end
        n_checks++; if (pulses_b != 6) begin n_fail++; $display("FAIL wrap_pulse_count: got %0d, expected 6", pulses_b); end
        n_checks++; if (exp_b.size() != 0) begin n_fail++; $display("FAIL wrap_sb_left: got %0d, expected 0", exp_b.size()); end
    endtask

    initial begin
        a_address = 2'd0; a_wdata = 32'h0;
        b_address = 2'd0; b_wdata = 32'h0;
        bus_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single_cmd();
        test_overflow();
        test_full_push_pop();
        test_flush_in_pulse();
        test_reset_in_pulse();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before 5 ms");
        $fatal(1, "watchdog expired");
    end
endmodule
